// File: rtl/ob_arb.sv
`default_nettype none
`ifndef PKTW
`define PKTW 9
`endif
// +----------------------------------------------------------------------+
// | ob_arb : round-robin output-port arbiter with flit forwarding        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ob_arb #(
  parameter int TMO = 64,
  parameter int CW  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [`PKTW:0]   pkt0,
  input  logic [`PKTW:0]   pkt1,
  input  logic [`PKTW:0]   pkt2,
  input  logic [`PKTW:0]   pkt3,
  input  logic             full,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic [`PKTW:0]   pkto,
  output logic             busy,
  output logic             err
);

  localparam int              FW      = `PKTW + 1;
  localparam logic [1:0]      T_TAIL  = 2'b11;
  localparam logic [CW-1:0]   WD_LAST = CW'(TMO - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      ptr, ptr_nx;
  logic [CW-1:0]   wd, wd_nx;
  logic [3:0]      ack_nx;
  logic [1:0]      sel_nx;
  logic [FW-1:0]   pkto_nx;
  logic            busy_nx;
  logic            err_nx;
  logic [FW-1:0]   cur;
  logic [1:0]      win;
  logic [1:0]      idx;

  always_comb begin
    case (sel)
      2'd0:    cur = pkt0;
      2'd1:    cur = pkt1;
      2'd2:    cur = pkt2;
      default: cur = pkt3;
    endcase
  end

  // Scan from the far end back toward ptr so the nearest requester is written last.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    wd_nx    = wd;
    ack_nx   = 4'b0000;
    sel_nx   = sel;
    pkto_nx  = pkto;
    busy_nx  = busy;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        pkto_nx = '0;
        if (|req && !full) begin
          ack_nx   = 4'b0001 << win;
          sel_nx   = win;
          state_nx = S_BUSY;
          busy_nx  = 1'b1;
          wd_nx    = '0;
        end
      end
      default: begin
        pkto_nx = cur;
        wd_nx   = wd + 1'b1;
        // A tail on the timeout edge still counts as a clean release.
        if (cur[FW-1:FW-2] == T_TAIL) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          ptr_nx   = sel + 2'd1;
        end else if (wd == WD_LAST) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          ptr_nx   = sel + 2'd1;
          pkto_nx  = '0;
          err_nx   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ptr   <= 2'd0;
      wd    <= '0;
      ack   <= 4'b0000;
      sel   <= 2'd0;
      pkto  <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      wd    <= wd_nx;
      ack   <= ack_nx;
      sel   <= sel_nx;
      pkto  <= pkto_nx;
      busy  <= busy_nx;
      err   <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: doc/ob_arb.md
# ob_arb

Output-port arbiter for the 4-port packet switch. One instance per output port sits between the four input buffers (`ib`) and the output link. It collects the per-input `req` bits that target this port and grants one input at a time round-robin with a one-cycle `ack` pulse. It then forwards that input's flits to `pkto` until the tail flit has passed. A watchdog releases the port if a tail never arrives.

## Interface
Parameters:
- `TMO`, 64: watchdog limit in BUSY cycles without a tail flit; legal range 2..(2^CW−1).
- `CW`, 7: watchdog counter width.

Flit width is `` `PKTW``+1 bits, taken from `sw.vh`. Flit type is bits [`` `PKTW``:`` `PKTW``−1]:
- 00: idle
- 10: head
- 01: body
- 11: tail

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, **asynchronous, active-low**; asserted (0) clears all state immediately.
- `req`  in  4  `req[i]` = input buffer i holds a head flit destined for this port.
- `pkt0`..`pkt3`  in  `` `PKTW``+1 each  current output flit of input buffers 0..3.
- `full`  in  1  downstream cannot accept a new packet; blocks new grants only.
- `ack`  out  4  one-hot grant pulse to the winning input buffer, 1 cycle wide.
- `sel`  out  2  index of the currently granted input.
- `pkto`  out  `` `PKTW``+1  registered forwarded flit; all-zero (idle) when not forwarding.
- `busy`  out  1  high while a packet owns the port.
- `err`  out  1  1-cycle pulse when the watchdog releases the port.

## Operation
- State is IDLE or BUSY. There is also a 2-bit round-robin pointer `ptr` and a CW-bit counter `wd`.
- Reset values: state IDLE, `ptr`=0, `wd`=0, `ack`=0, `sel`=0, `pkto`=0, `busy`=0, `err`=0.
- **IDLE, edge with `|req` and `!full`:**
  - Winner = first i with `req[i]`=1, searching `ptr`, `ptr`+1, … mod 4.
  - Register `ack`=one-hot(winner) and `sel`=winner.
  - Go to BUSY, set `busy`=1, clear `wd`.
  - `pkto` stays 0.
- **IDLE, edge with `full`=1 or `req`=0:** no grant; outputs unchanged except `ack`=0 and `err`=0.
- **BUSY, every edge:**
  - `ack` <= 0.
  - `pkto` <= `pkt[sel]`. The granted buffer still holds the head flit during the ack cycle, so the head is the first flit captured.
  - `wd` <= `wd`+1.
- **BUSY, captured flit has type 11:**
  - Go to IDLE on that edge; `pkto` shows the tail for that cycle.
  - `busy` <= 0, `ptr` <= `sel`+1 mod 4 (wraps 3 -> 0).
- **BUSY, `wd` reaches TMO−1 with no tail:**
  - Go to IDLE, `pkto` <= 0, `err` <= 1 for one cycle.
  - `ptr` <= `sel`+1 mod 4, `busy` <= 0.
- If a tail and the timeout occur on the same edge, the tail wins: normal release, `err`=0.
- Idle flits (00) in BUSY are forwarded as bubbles and do not end the packet.
- `req` changes and `full` are ignored while BUSY.
- A new `req` from the just-released input only wins again after lower-priority requesters are served; it competes under the updated `ptr`.

## Timing
- Grant latency: 1 edge from the first edge sampling `req` with `!full` to `ack` high.
- `ack` is high for exactly one clock.
- Forwarding latency: `pkto` = `pkt[sel]` delayed by one clock.
  - The head appears on `pkto` the cycle after `ack` falls.
- Release: state is IDLE in the cycle `pkto` shows the tail.
  - Earliest next `ack` is the following edge, so there are 0 dead cycles between tail-out and the next grant decision.
- Reset asserted mid-packet:
  - All outputs go to reset values asynchronously, without waiting for a clock edge.
  - The partial packet is dropped; `ptr` returns to 0.

## Test plan
- **Single grant:** `req`=0001, pkt0 = head 10_0000_0000, body, body, tail 11_0000_0010 (input advances after `ack`).
  - `ack`=0001 for 1 cycle.
  - `pkto` reproduces all 4 flits 1 cycle delayed.
  - `busy` drops with the tail; `ptr`=1.
- **Round-robin:** `req`=1111 held, each packet 3 flits.
  - Grant order is 0,1,2,3,0.
  - `ack` pulses are spaced by packet length + 1 cycle.
- **Full blocking:** `req`=0100 with `full`=1 for 5 cycles, then `full`=0.
  - No `ack` during those 5 cycles.
  - `ack`=0100 one edge after `full` falls.
- **Watchdog:** grant input 2 with `TMO`=8 and no tail sent.
  - After 8 BUSY cycles, `err` pulses once, `busy`=0, `pkto`=0, `ptr`=3.
- **Tail vs. timeout:** tail captured on the same edge that the counter reaches TMO−1.
  - `err` stays 0 and a normal release occurs.
- **Async reset mid-packet:** drop `rst` between clock edges during a body flit.
  - `busy`, `pkto`, and `ack` are 0 immediately.
  - After release, `req`=1000 is granted with `ptr` starting at 0.
